// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word load/store at a time, holds it for a
// fixed latency, then presents the response until the requester takes it.
module dmem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_we,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    // state | meaning
    // IDLE  | ready for a request
    // WAIT  | latency countdown in progress
    // RESP  | response presented, waiting for rsp_ready
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 rsp_we_q, rsp_we_d;
    logic [15:0]          rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 mem_we;
    logic                 addr_err;
    logic [ADDR_BITS-1:0] mem_idx;
    logic [15:0]          mem_q [DEPTH];

    // Every address bit above the implemented range must be zero.
    generate
        if (ADDR_BITS < 16) begin : g_err
            assign addr_err = |req_addr[15:ADDR_BITS];
        end else begin : g_no_err
            assign addr_err = 1'b0;
        end
    endgenerate

    assign mem_idx   = req_addr[ADDR_BITS-1:0];
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_we    = rsp_we_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_we_d   = rsp_we_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rsp_we_d   = req_we;
                    rsp_err_d  = addr_err;
                    rsp_data_d = (!req_we && !addr_err) ? mem_q[mem_idx] : 16'h0000;
                    mem_we     = req_we && !addr_err;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d    = IDLE;
                    rsp_data_d = 16'h0000;
                    rsp_err_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rsp_we_q   <= 1'b0;
            rsp_data_q <= 16'h0000;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_we_q   <= rsp_we_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Array contents survive reset, so a committed store outlives an aborted response.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance,
// expected responses queued at issue time and checked by per-instance monitors.
module tb_dmem_responder;

    typedef struct packed {
        logic        we;
        logic [15:0] data;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid0 = 0, req_we0 = 0, rsp_ready0 = 0;
    logic [15:0] req_addr0 = 0, req_wdata0 = 0;
    logic        req_ready0, rsp_valid0, rsp_we0, rsp_err0, busy0;
    logic [15:0] rsp_data0;

    logic        req_valid1 = 0, req_we1 = 0, rsp_ready1 = 0;
    logic [15:0] req_addr1 = 0, req_wdata1 = 0;
    logic        req_ready1, rsp_valid1, rsp_we1, rsp_err1, busy1;
    logic [15:0] rsp_data1;

    rsp_t sb0[$];
    rsp_t sb1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_BITS(8), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_we(rsp_we0),
        .rsp_data(rsp_data0), .rsp_err(rsp_err0), .busy(busy0)
    );

    dmem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_we(rsp_we1),
        .rsp_data(rsp_data1), .rsp_err(rsp_err1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: a handshake sampled at the negedge completes on the next posedge.
    always @(negedge clk) begin
        if (!reset && rsp_valid0 && rsp_ready0) begin
            if (sb0.size() == 0) begin
                chk("sb0_unexpected_rsp", 16'(sb0.size()), 16'd1);
            end else begin
                rsp_t e;
                e = sb0.pop_front();
                chk("rsp0_we",   {15'b0, rsp_we0},  {15'b0, e.we});
                chk("rsp0_data", rsp_data0,         e.data);
                chk("rsp0_err",  {15'b0, rsp_err0}, {15'b0, e.err});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && rsp_valid1 && rsp_ready1) begin
            if (sb1.size() == 0) begin
                chk("sb1_unexpected_rsp", 16'(sb1.size()), 16'd1);
            end else begin
                rsp_t e;
                e = sb1.pop_front();
                chk("rsp1_we",   {15'b0, rsp_we1},  {15'b0, e.we});
                chk("rsp1_data", rsp_data1,         e.data);
                chk("rsp1_err",  {15'b0, rsp_err1}, {15'b0, e.err});
            end
        end
    end

    // Returns 2 time units after the accept edge with req_valid0 dropped.
    task automatic issue0(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] exp_data, input logic exp_err);
        int n = 0;
        @(posedge clk); #2;
        req_valid0 = 1; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata;
        @(negedge clk);
        while (!req_ready0 && n < 40) begin @(negedge clk); n++; end
        chk("accept0", {15'b0, req_ready0}, 16'd1);
        sb0.push_back('{we, exp_data, exp_err});
        @(posedge clk); #2;
        req_valid0 = 0; req_addr0 = 16'hFFFF; req_wdata0 = 16'h0BAD;
    endtask

    task automatic issue1(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] exp_data, input logic exp_err);
        int n = 0;
        @(posedge clk); #2;
        req_valid1 = 1; req_we1 = we; req_addr1 = addr; req_wdata1 = wdata;
        @(negedge clk);
        while (!req_ready1 && n < 40) begin @(negedge clk); n++; end
        chk("accept1", {15'b0, req_ready1}, 16'd1);
        sb1.push_back('{we, exp_data, exp_err});
        @(posedge clk); #2;
        req_valid1 = 0;
    endtask

    task automatic drain0();
        int n = 0;
        @(negedge clk);
        while ((sb0.size() != 0 || !req_ready0) && n < 60) begin @(negedge clk); n++; end
        chk("drain0", 16'(sb0.size()), 16'd0);
    endtask

    task automatic drain1();
        int n = 0;
        @(negedge clk);
        while ((sb1.size() != 0 || !req_ready1) && n < 60) begin @(negedge clk); n++; end
        chk("drain1", 16'(sb1.size()), 16'd0);
    endtask

    initial begin
        int n;
        int t0, t1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {15'b0, req_ready0}, 16'd1);
        chk("rst_rsp_valid", {15'b0, rsp_valid0}, 16'd0);
        chk("rst_rsp_we",    {15'b0, rsp_we0},    16'd0);
        chk("rst_rsp_data",  rsp_data0,           16'h0000);
        chk("rst_rsp_err",   {15'b0, rsp_err0},   16'd0);
        chk("rst_busy",      {15'b0, busy0},      16'd0);
        @(posedge clk); #2 reset = 0;

        // Store 0x0005 = 0xBEEF with cycle-level timing
        rsp_ready0 = 1;
        issue0(1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0);
        @(negedge clk);
        chk("st_wait_valid", {15'b0, rsp_valid0}, 16'd0);
        chk("st_wait_busy",  {15'b0, busy0},      16'd1);
        chk("st_wait_ready", {15'b0, req_ready0}, 16'd0);
        @(negedge clk);
        chk("st_resp_valid", {15'b0, rsp_valid0}, 16'd1);
        @(negedge clk);
        chk("st_done_valid", {15'b0, rsp_valid0}, 16'd0);
        chk("st_done_ready", {15'b0, req_ready0}, 16'd1);
        chk("st_we_held",    {15'b0, rsp_we0},    16'd1);
        chk("st_data_clr",   rsp_data0,           16'h0000);

        // Load back
        issue0(1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0);
        drain0();

        // Backpressure: response held, competing request ignored
        rsp_ready0 = 0;
        issue0(1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0);
        n = 0;
        while (!rsp_valid0 && n < 20) begin @(negedge clk); n++; end
        chk("bp_valid_seen", {15'b0, rsp_valid0}, 16'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            req_valid0 = 1; req_we0 = 1; req_addr0 = 16'h0005; req_wdata0 = 16'hDEAD;
            @(negedge clk);
            chk("bp_valid", {15'b0, rsp_valid0}, 16'd1);
            chk("bp_data",  rsp_data0,           16'hBEEF);
            chk("bp_ready", {15'b0, req_ready0}, 16'd0);
            chk("bp_busy",  {15'b0, busy0},      16'd1);
        end
        @(posedge clk); #2;
        req_valid0 = 0; rsp_ready0 = 1;
        drain0();

        // Out-of-range store and loads
        issue0(1'b1, 16'h0105, 16'h1234, 16'h0000, 1'b1);
        issue0(1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0);
        issue0(1'b0, 16'h0105, 16'h0000, 16'h0000, 1'b1);
        issue0(1'b0, 16'h8005, 16'h0000, 16'h0000, 1'b1);
        issue0(1'b1, 16'h00FF, 16'hC3C3, 16'h0000, 1'b0);
        issue0(1'b0, 16'h00FF, 16'h0000, 16'hC3C3, 1'b0);
        drain0();

        // Reset while in WAIT: response discarded, store committed
        issue0(1'b1, 16'h0007, 16'h00AA, 16'h0000, 1'b0);
        reset = 1;
        void'(sb0.pop_back());
        @(negedge clk);
        chk("rw_valid", {15'b0, rsp_valid0}, 16'd0);
        chk("rw_ready", {15'b0, req_ready0}, 16'd1);
        chk("rw_busy",  {15'b0, busy0},      16'd0);
        chk("rw_we",    {15'b0, rsp_we0},    16'd0);
        @(posedge clk); #2 reset = 0;
        issue0(1'b0, 16'h0007, 16'h0000, 16'h00AA, 1'b0);
        drain0();

        // LATENCY=1 instance
        rsp_ready1 = 1;
        issue1(1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0);
        issue1(1'b1, 16'h0006, 16'h5A5A, 16'h0000, 1'b0);
        drain1();

        @(posedge clk); #2;
        req_valid1 = 1; req_we1 = 0; req_addr1 = 16'h0005;
        sb1.push_back('{1'b0, 16'hBEEF, 1'b0});
        n = 0;
        @(negedge clk);
        while (!req_ready1 && n < 20) begin @(negedge clk); n++; end
        t0 = cyc;
        @(posedge clk); #2;
        req_addr1 = 16'h0006;
        sb1.push_back('{1'b0, 16'h5A5A, 1'b0});
        @(negedge clk);
        chk("l1_valid_next", {15'b0, rsp_valid1}, 16'd1);
        chk("l1_ready_low",  {15'b0, req_ready1}, 16'd0);
        n = 0;
        @(negedge clk);
        while (!req_ready1 && n < 20) begin @(negedge clk); n++; end
        t1 = cyc;
        chk("l1_b2b_spacing", 16'(t1 - t0), 16'd2);
        @(posedge clk); #2;
        req_valid1 = 0;
        drain1();

        repeat (3) @(negedge clk);
        chk("sb0_empty", 16'(sb0.size()), 16'd0);
        chk("sb1_empty", 16'(sb1.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
